// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller.
package hazard_pkg;

    localparam int unsigned FWD_SEL_W = 2;

    // E-stage operand source selects
    localparam logic [FWD_SEL_W-1:0] FWD_REG = 2'b00;
    localparam logic [FWD_SEL_W-1:0] FWD_W   = 2'b01;
    localparam logic [FWD_SEL_W-1:0] FWD_M   = 2'b10;

    // Deferred-redirect FSM
    typedef enum logic {
        S_RUN        = 1'b0,
        S_FLUSH_PEND = 1'b1
    } state_t;

    // M result wins over W when both hold the newest copy of a register
    function automatic logic [FWD_SEL_W-1:0] fwd_sel(input logic m_hit, input logic w_hit);
        logic [FWD_SEL_W-1:0] sel;
        sel = FWD_REG;
        if (m_hit) begin
            sel = FWD_M;
        end else if (w_hit) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

endpackage

// File: rtl/div_stall_cnt.sv
// Divide latency counter: holds E for DIV_LAT cycles per divide and
// remembers completion so a held divide is not restarted.
module div_stall_cnt #(
    parameter int unsigned DIV_LAT = 32,
    parameter int unsigned CNT_W   = 8
) (
    input  logic clk,
    input  logic resetn,
    input  logic div_start,
    input  logic stall_e,
    input  logic clear,
    output logic div_stall,
    output logic div_busy
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic             div_done;
    logic             start;

    // First cycle of a new divide in E
    assign start     = div_start & (cnt == '0) & ~div_done;
    assign div_stall = start | (cnt != '0);
    assign div_busy  = (cnt != '0);

    // Counter and completion flag; an exception abandons the divide
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt      <= '0;
            div_done <= 1'b0;
        end else if (clear) begin
            cnt      <= '0;
            div_done <= 1'b0;
        end else begin
            if (start) begin
                cnt <= LOAD_VAL;
            end else if (cnt != '0) begin
                cnt <= cnt - ONE;
            end

            if (cnt == ONE) begin
                div_done <= 1'b1;
            end else if (!stall_e) begin
                div_done <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: forwarding selects,
// per-stage stall/flush priority and exception redirect sequencing.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned REG_AW  = 5,
    parameter int unsigned DIV_LAT = 32,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [REG_AW-1:0]    rs_d,
    input  logic [REG_AW-1:0]    rt_d,
    input  logic                 branch_d,
    input  logic [REG_AW-1:0]    rs_e,
    input  logic [REG_AW-1:0]    rt_e,
    input  logic [REG_AW-1:0]    wreg_e,
    input  logic                 regwrite_e,
    input  logic                 memtoreg_e,
    input  logic                 div_start_e,
    input  logic [REG_AW-1:0]    wreg_m,
    input  logic                 regwrite_m,
    input  logic                 memtoreg_m,
    input  logic [REG_AW-1:0]    wreg_w,
    input  logic                 regwrite_w,
    input  logic                 imem_busy,
    input  logic                 dmem_busy,
    input  logic                 except_m,
    output logic                 fwd_a_d,
    output logic                 fwd_b_d,
    output logic [FWD_SEL_W-1:0] fwd_a_e,
    output logic [FWD_SEL_W-1:0] fwd_b_e,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 stall_e,
    output logic                 stall_m,
    output logic                 flush_d,
    output logic                 flush_e,
    output logic                 flush_m,
    output logic                 flush_w,
    output logic                 redirect,
    output logic                 div_busy
);

    state_t state;
    state_t state_next;
    logic   pend;
    logic   exc;
    logic   lw_stall;
    logic   br_stall;
    logic   div_stall;
    logic   div_clear;

    // Forwarding selects; register 0 never matches
    always_comb begin
        fwd_a_d = (rs_d != '0) & (rs_d == wreg_m) & regwrite_m;
        fwd_b_d = (rt_d != '0) & (rt_d == wreg_m) & regwrite_m;
        fwd_a_e = fwd_sel((rs_e != '0) & (rs_e == wreg_m) & regwrite_m,
                          (rs_e != '0) & (rs_e == wreg_w) & regwrite_w);
        fwd_b_e = fwd_sel((rt_e != '0) & (rt_e == wreg_m) & regwrite_m,
                          (rt_e != '0) & (rt_e == wreg_w) & regwrite_w);
    end

    // Load-use and branch-operand hazard detection
    always_comb begin
        lw_stall = memtoreg_e & (rt_e != '0) & ((rt_e == rs_d) | (rt_e == rt_d));
        br_stall = branch_d &
                   ((regwrite_e & (wreg_e != '0) & ((wreg_e == rs_d) | (wreg_e == rt_d))) |
                    (memtoreg_m & (wreg_m != '0) & ((wreg_m == rs_d) | (wreg_m == rt_d))));
    end

    assign pend      = (state == S_FLUSH_PEND);
    assign exc       = ~pend & except_m;
    assign div_clear = pend | exc;

    div_stall_cnt #(
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) u_div_cnt (
        .clk       (clk),
        .resetn    (resetn),
        .div_start (div_start_e),
        .stall_e   (stall_e),
        .clear     (div_clear),
        .div_stall (div_stall),
        .div_busy  (div_busy)
    );

    // Redirect FSM state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state and prioritised stall/flush/redirect generation
    always_comb begin
        state_next = state;
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        stall_e    = 1'b0;
        stall_m    = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        flush_m    = 1'b0;
        flush_w    = 1'b0;
        redirect   = 1'b0;

        if (pend) begin
            stall_f = 1'b1;
            flush_d = 1'b1;
            if (!imem_busy) begin
                redirect   = 1'b1;
                state_next = S_RUN;
            end
        end else if (exc) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_m = 1'b1;
            flush_w = 1'b1;
            if (imem_busy) begin
                state_next = S_FLUSH_PEND;
            end else begin
                redirect = 1'b1;
            end
        end else if (dmem_busy) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (div_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
        end else if (lw_stall | br_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end else if (imem_busy) begin
            stall_f = 1'b1;
            flush_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a cycle model checked every
// negedge, plus directed literal expectations along the stimulus.
module tb_hazard_ctrl;

    localparam int unsigned REG_AW  = 5;
    localparam int unsigned DIV_LAT = 4;
    localparam int unsigned CNT_W   = 8;

    logic              clk;
    logic              resetn;
    logic [REG_AW-1:0] rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w;
    logic              branch_d, regwrite_e, memtoreg_e, div_start_e;
    logic              regwrite_m, memtoreg_m, regwrite_w;
    logic              imem_busy, dmem_busy, except_m;
    logic              fwd_a_d, fwd_b_d;
    logic [1:0]        fwd_a_e, fwd_b_e;
    logic              stall_f, stall_d, stall_e, stall_m;
    logic              flush_d, flush_e, flush_m, flush_w;
    logic              redirect, div_busy;
    logic [15:0]       outs;

    int vectors     = 0;
    int miscompares = 0;

    hazard_ctrl #(
        .REG_AW  (REG_AW),
        .DIV_LAT (DIV_LAT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .rs_d        (rs_d),
        .rt_d        (rt_d),
        .branch_d    (branch_d),
        .rs_e        (rs_e),
        .rt_e        (rt_e),
        .wreg_e      (wreg_e),
        .regwrite_e  (regwrite_e),
        .memtoreg_e  (memtoreg_e),
        .div_start_e (div_start_e),
        .wreg_m      (wreg_m),
        .regwrite_m  (regwrite_m),
        .memtoreg_m  (memtoreg_m),
        .wreg_w      (wreg_w),
        .regwrite_w  (regwrite_w),
        .imem_busy   (imem_busy),
        .dmem_busy   (dmem_busy),
        .except_m    (except_m),
        .fwd_a_d     (fwd_a_d),
        .fwd_b_d     (fwd_b_d),
        .fwd_a_e     (fwd_a_e),
        .fwd_b_e     (fwd_b_e),
        .stall_f     (stall_f),
        .stall_d     (stall_d),
        .stall_e     (stall_e),
        .stall_m     (stall_m),
        .flush_d     (flush_d),
        .flush_e     (flush_e),
        .flush_m     (flush_m),
        .flush_w     (flush_w),
        .redirect    (redirect),
        .div_busy    (div_busy)
    );

    assign outs = {fwd_a_d, fwd_b_d, fwd_a_e, fwd_b_e, stall_f, stall_d, stall_e, stall_m,
                   flush_d, flush_e, flush_m, flush_w, redirect, div_busy};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    // m_owed: divide stall cycles still owed after the current one
    // m_fin : the divide now sitting in E has already served its latency
    int   m_owed = 0;
    logic m_fin  = 1'b0;
    logic m_pend = 1'b0;
    // values sampled at negedge, consumed at the following posedge
    logic s_clear = 1'b0, s_start = 1'b0, s_stall_e = 1'b0, s_pend_next = 1'b0;

    function automatic logic [1:0] exp_fwd_e(input logic [REG_AW-1:0] src);
        if (src != 0 && src == wreg_m && regwrite_m) return 2'd2;
        if (src != 0 && src == wreg_w && regwrite_w) return 2'd1;
        return 2'd0;
    endfunction

    function automatic logic hits(input logic [REG_AW-1:0] dst);
        return dst != 0 && (dst == rs_d || dst == rt_d);
    endfunction

    // Compare process: recompute every output from the rules each cycle
    always @(negedge clk) begin : cmp
        logic        exc, start, divact, lw, br;
        logic        e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fm, e_fw, e_red, pend_next;
        logic [15:0] expv;
        exc    = !m_pend && except_m;
        start  = div_start_e && m_owed == 0 && !m_fin;
        divact = m_owed > 0 || start;
        lw     = memtoreg_e && rt_e != 0 && (rt_e == rs_d || rt_e == rt_d);
        br     = branch_d && ((regwrite_e && hits(wreg_e)) || (memtoreg_m && hits(wreg_m)));
        {e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fm, e_fw, e_red} = '0;
        pend_next = m_pend;
        if (m_pend) begin
            e_sf = 1; e_fd = 1;
            if (!imem_busy) begin e_red = 1; pend_next = 0; end
        end else if (exc) begin
            {e_fd, e_fe, e_fm, e_fw} = 4'hF;
            if (imem_busy) pend_next = 1; else e_red = 1;
        end else if (dmem_busy) begin
            {e_sf, e_sd, e_se, e_sm, e_fw} = 5'h1F;
        end else if (divact) begin
            {e_sf, e_sd, e_se, e_fm} = 4'hF;
        end else if (lw || br) begin
            {e_sf, e_sd, e_fe} = 3'h7;
        end else if (imem_busy) begin
            {e_sf, e_fd} = 2'h3;
        end
        expv = {(rs_d != 0 && rs_d == wreg_m && regwrite_m),
                (rt_d != 0 && rt_d == wreg_m && regwrite_m),
                exp_fwd_e(rs_e), exp_fwd_e(rt_e),
                e_sf, e_sd, e_se, e_sm, e_fd, e_fe, e_fm, e_fw, e_red, (m_owed > 0)};
        vectors++;
        if (outs !== expv) begin
            miscompares++;
            $display("FAIL cycle_model t=%0t got %h expected %h", $time, outs, expv);
        end
        s_clear     = m_pend || exc;
        s_start     = start;
        s_stall_e   = e_se;
        s_pend_next = pend_next;
    end

    // Model state advance
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_owed = 0; m_fin = 0; m_pend = 0;
        end else begin
            if (s_clear) begin
                m_owed = 0; m_fin = 0;
            end else begin
                if (m_owed > 0) begin
                    m_owed = m_owed - 1;
                    if (m_owed == 0) m_fin = 1;
                end else if (s_start) begin
                    m_owed = DIV_LAT - 1;
                end
                if (!s_stall_e) m_fin = 0;
            end
            m_pend = s_pend_next;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clr;
        {rs_d, rt_d, rs_e, rt_e, wreg_e, wreg_m, wreg_w} = '0;
        {branch_d, regwrite_e, memtoreg_e, div_start_e} = '0;
        {regwrite_m, memtoreg_m, regwrite_w} = '0;
        {imem_busy, dmem_busy, except_m} = '0;
    endtask

    initial begin
        clr();
        resetn = 1'b0;
        repeat (2) tick();
        #2 chk("reset_outs", outs, 16'h0);
        tick();
        resetn = 1'b1;

        // load-use
        tick(); memtoreg_e = 1; rt_e = 2; rs_d = 2;
        #2 chk("lw_stall", {stall_f, stall_d, stall_e, flush_e}, 4'b1101);
        tick(); rt_e = 0; rs_d = 0;
        #2 chk("lw_r0", {stall_f, stall_d, flush_e}, 3'b000);

        // forwarding
        tick(); clr(); rs_e = 5; wreg_m = 5; regwrite_m = 1; wreg_w = 5; regwrite_w = 1;
        #2 chk("fwd_m_prio", fwd_a_e, 2'b10);
        tick(); regwrite_m = 0;
        #2 chk("fwd_w", fwd_a_e, 2'b01);
        tick(); rs_e = 0; wreg_m = 0; regwrite_m = 1; wreg_w = 0;
        #2 chk("fwd_r0", fwd_a_e, 2'b00);
        tick(); clr(); rs_d = 9; rt_d = 9; wreg_m = 9; regwrite_m = 1;
        #2 chk("fwd_d", {fwd_a_d, fwd_b_d, stall_d}, 3'b110);

        // branch operand
        tick(); clr(); branch_d = 1; rs_d = 3; regwrite_e = 1; wreg_e = 3;
        #2 chk("br_e", {stall_f, stall_d, flush_e, stall_e}, 4'b1110);
        tick(); clr(); branch_d = 1; rt_d = 4; memtoreg_m = 1; wreg_m = 4; regwrite_m = 1;
        #2 chk("br_m_load", {stall_f, stall_d, flush_e, fwd_b_d}, 4'b1111);
        tick(); clr(); branch_d = 1; regwrite_e = 1;
        #2 chk("br_r0", {stall_f, stall_d, flush_e}, 3'b000);

        // divide: E held exactly DIV_LAT cycles
        tick(); clr(); div_start_e = 1;
        for (int i = 0; i < 5; i++) begin
            #2 chk($sformatf("div_c%0d", i), {stall_e, flush_m, div_busy},
                   (i < 4) ? {2'b11, (i != 0)} : 3'b000);
            tick();
        end
        #2 chk("div_restart", {stall_e, div_busy}, 2'b10);
        tick();
        tick(); memtoreg_e = 1; rt_e = 6; rs_d = 6;
        #2 chk("div_lw", {stall_e, flush_m, flush_e, stall_d, div_busy}, 5'b11011);
        tick(); except_m = 1;
        #2 chk("div_exc", {flush_d, flush_e, flush_m, flush_w, redirect, stall_e}, 6'b111110);
        tick(); clr();
        #2 chk("div_killed", {stall_e, div_busy}, 2'b00);

        // exception while fetch outstanding
        tick(); clr(); except_m = 1; imem_busy = 1;
        #2 chk("exc_busy", {flush_d, flush_e, flush_m, flush_w, redirect, stall_f}, 6'b111100);
        tick();
        #2 chk("pend1", {stall_f, flush_d, flush_e, redirect}, 4'b1100);
        tick();
        #2 chk("pend2", {stall_f, flush_d, flush_e, redirect}, 4'b1100);
        tick(); imem_busy = 0;
        #2 chk("pend_redirect", {stall_f, flush_d, redirect}, 3'b111);
        tick(); except_m = 0;
        #2 chk("pend_done", {stall_f, redirect}, 2'b00);

        // data memory busy over branch stall
        tick(); clr(); branch_d = 1; rs_d = 3; regwrite_e = 1; wreg_e = 3; dmem_busy = 1;
        repeat (2) begin
            #2 chk("dmem_br", {stall_f, stall_d, stall_e, stall_m, flush_w, flush_e}, 6'b111110);
            tick();
        end
        dmem_busy = 0;
        #2 chk("dmem_release", {stall_e, stall_m, flush_e}, 3'b001);
        tick(); clr(); dmem_busy = 1; except_m = 1;
        #2 chk("dmem_masked", {stall_m, flush_w, redirect}, 3'b011);

        // fetch busy
        tick(); clr(); imem_busy = 1;
        #2 chk("imem_only", {stall_f, flush_d}, 2'b11);
        tick(); memtoreg_e = 1; rt_e = 2; rs_d = 2;
        #2 chk("imem_lw", {stall_f, stall_d, flush_d, flush_e}, 4'b1101);

        // asynchronous reset mid-divide
        tick(); clr(); div_start_e = 1;
        tick(); div_start_e = 0;
        #2 chk("div_run", {stall_e, div_busy}, 2'b11);
        tick(); resetn = 0;
        #1 chk("async_reset", outs, 16'h0);
        tick(); resetn = 1;
        tick();
        #2 chk("post_reset", outs, 16'h0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
